// File: rtl/reaction_display_pkg.sv
// Shared constants for the reaction-time display stage:
// FSM states, 7-segment glyphs, digit codes and decode helpers.
package reaction_display_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // {a,b,c,d,e,f,g,dp}, active-low, dp always off
    localparam logic [7:0] G_0     = 8'b0000001_1;
    localparam logic [7:0] G_1     = 8'b1001111_1;
    localparam logic [7:0] G_2     = 8'b0010010_1;
    localparam logic [7:0] G_3     = 8'b0000110_1;
    localparam logic [7:0] G_4     = 8'b1001100_1;
    localparam logic [7:0] G_5     = 8'b0100100_1;
    localparam logic [7:0] G_6     = 8'b0100000_1;
    localparam logic [7:0] G_7     = 8'b0001111_1;
    localparam logic [7:0] G_8     = 8'b0000000_1;
    localparam logic [7:0] G_9     = 8'b0000100_1;
    localparam logic [7:0] G_E     = 8'b0110000_1;
    localparam logic [7:0] G_R     = 8'b1111010_1;
    localparam logic [7:0] G_DASH  = 8'b1111110_1;
    localparam logic [7:0] G_BLANK = 8'b1111111_1;

    localparam logic [3:0] D_E     = 4'hA;
    localparam logic [3:0] D_R     = 4'hB;
    localparam logic [3:0] D_DASH  = 4'hC;
    localparam logic [3:0] D_BLANK = 4'hF;

    localparam logic [15:0] MAX_DISPLAY = 16'd9999;

    function automatic logic [7:0] glyph_of(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = G_0;
            4'h1:    g = G_1;
            4'h2:    g = G_2;
            4'h3:    g = G_3;
            4'h4:    g = G_4;
            4'h5:    g = G_5;
            4'h6:    g = G_6;
            4'h7:    g = G_7;
            4'h8:    g = G_8;
            4'h9:    g = G_9;
            D_E:     g = G_E;
            D_R:     g = G_R;
            D_DASH:  g = G_DASH;
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

    // Zero digits become blank only while every digit to their left is blank.
    function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
        logic b3, b2, b1;
        b3 = (bcd[15:12] == 4'd0);
        b2 = b3 && (bcd[11:8] == 4'd0);
        b1 = b2 && (bcd[7:4] == 4'd0);
        return {b3 ? D_BLANK : bcd[15:12],
                b2 ? D_BLANK : bcd[11:8],
                b1 ? D_BLANK : bcd[7:4],
                bcd[3:0]};
    endfunction

endpackage

// File: rtl/reaction_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Ports: clk, reset, start (accepted when idle), bin, done (last shift), bcd.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [15:0] bcd
);
    import reaction_display_pkg::*;

    logic [15:0] bin_r;
    logic [15:0] bcd_r;
    logic [15:0] adj;
    logic [3:0]  cnt;
    logic        active;

    always_comb begin
        adj = bcd_r;
        for (int i = 0; i < 4; i++) begin
            if (bcd_r[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
        end
    end

    // done marks the cycle whose edge performs the 16th shift
    assign done = active && (cnt == 4'd15);
    assign bcd  = bcd_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_r  <= '0;
            bcd_r  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start && !active) begin
            bin_r  <= bin;
            bcd_r  <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            {bcd_r, bin_r} <= {adj[14:0], bin_r, 1'b0};
            cnt            <= cnt + 4'd1;
            if (cnt == 4'd15)
                active <= 1'b0;
        end
    end
endmodule

// File: rtl/reaction_display.sv
// Reaction-time display: BCD conversion, blanking, glyphs and anode scan.
// Ports: clk, reset, result/result_valid/error in; busy, anode, cathodes out.
module reaction_display #(
    parameter int SCAN_DIV      = 32768,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        result_valid,
    input  logic        error,
    output logic        busy,
    output logic [3:0]  anode,
    output logic [7:0]  cathodes
);
    import reaction_display_pkg::*;

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [1:0]    state;
    logic [15:0]   glyph_codes;
    logic          use_glyph;
    logic [15:0]   disp;
    logic [CW-1:0] scan_cnt;
    logic          start;
    logic          conv_done;
    logic [15:0]   bcd;
    logic [3:0]    sel;

    assign busy  = (state != ST_IDLE);
    assign start = (state == ST_IDLE) && result_valid && !error
                   && (result <= MAX_DISPLAY);

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (result),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            glyph_codes <= {4{D_BLANK}};
            use_glyph   <= 1'b0;
            disp        <= {D_BLANK, D_BLANK, D_BLANK, 4'h0};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (result_valid) begin
                        if (error) begin
                            glyph_codes <= {D_E, D_R, D_R, D_BLANK};
                            use_glyph   <= 1'b1;
                            state       <= ST_COMMIT;
                        end else if (result > MAX_DISPLAY) begin
                            glyph_codes <= {4{D_DASH}};
                            use_glyph   <= 1'b1;
                            state       <= ST_COMMIT;
                        end else begin
                            use_glyph <= 1'b0;
                            state     <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    if (conv_done)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (use_glyph)
                        disp <= glyph_codes;
                    else if (BLANK_LEADING)
                        disp <= blank_leading(bcd);
                    else
                        disp <= bcd;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            anode    <= 4'b0111;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            anode    <= {anode[0], anode[3:1]};
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    always_comb begin
        sel = disp[3:0];
        case (anode)
            4'b0111: sel = disp[15:12];
            4'b1011: sel = disp[11:8];
            4'b1101: sel = disp[7:4];
            default: sel = disp[3:0];
        endcase
        cathodes = glyph_of(sel);
    end
endmodule

// File: tb/tb_reaction_display.sv
// Directed self-checking bench for reaction_display.
// Two instances share stimulus: blanking on and blanking off.
module tb_reaction_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] result = '0;
    logic        result_valid = 1'b0;
    logic        error = 1'b0;
    logic        busy, busy0;
    logic [3:0]  anode, anode0;
    logic [7:0]  cathodes, cath0;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] C0 = 8'b00000011;
    localparam logic [7:0] C1 = 8'b10011111;
    localparam logic [7:0] C2 = 8'b00100101;
    localparam logic [7:0] C3 = 8'b00001101;
    localparam logic [7:0] C4 = 8'b10011001;
    localparam logic [7:0] C5 = 8'b01001001;
    localparam logic [7:0] C7 = 8'b00011111;
    localparam logic [7:0] C9 = 8'b00001001;
    localparam logic [7:0] CE = 8'b01100001;
    localparam logic [7:0] CR = 8'b11110101;
    localparam logic [7:0] CD = 8'b11111101;
    localparam logic [7:0] CB = 8'b11111111;

    always #5 clk = ~clk;

    reaction_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .result(result),
        .result_valid(result_valid), .error(error),
        .busy(busy), .anode(anode), .cathodes(cathodes)
    );

    reaction_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .reset(reset), .result(result),
        .result_valid(result_valid), .error(error),
        .busy(busy0), .anode(anode0), .cathodes(cath0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input logic [3:0] a);
        case (a)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic check_disp(input string tag, input logic [31:0] e1,
                              input logic [31:0] e0);
        logic [7:0] c1 [4];
        logic [7:0] c0 [4];
        for (int i = 0; i < 4; i++) begin
            c1[i] = 8'hxx;
            c0[i] = 8'hxx;
        end
        for (int i = 0; i < 16; i++) begin
            c1[pos_of(anode)]  = cathodes;
            c0[pos_of(anode0)] = cath0;
            tick;
        end
        chk({tag, "_blank"}, {c1[3], c1[2], c1[1], c1[0]}, e1);
        chk({tag, "_noblank"}, {c0[3], c0[2], c0[1], c0[0]}, e0);
    endtask

    task automatic strobe(input logic [15:0] r, input logic e);
        result       = r;
        error        = e;
        result_valid = 1'b1;
        tick;
        result_valid = 1'b0;
        error        = 1'b0;
    endtask

    task automatic run_num(input string tag, input logic [15:0] r);
        strobe(r, 1'b0);
        for (int i = 0; i < 17; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            tick;
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0] seq [5];
        seq[0] = 4'b0111;
        seq[1] = 4'b1011;
        seq[2] = 4'b1101;
        seq[3] = 4'b1110;
        seq[4] = 4'b0111;

        reset = 1'b1;
        tick;
        tick;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cath", {24'd0, cathodes}, {24'd0, CB});
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("scan_anode", {28'd0, anode}, {28'd0, seq[k/4]});
            tick;
        end
        check_disp("rst_disp", {CB, CB, CB, C0}, {CB, CB, CB, C0});

        run_num("n1234", 16'd1234);
        check_disp("d1234", {C1, C2, C3, C4}, {C1, C2, C3, C4});

        run_num("n7", 16'd7);
        check_disp("d7", {CB, CB, CB, C7}, {C0, C0, C0, C7});

        run_num("n1005", 16'd1005);
        check_disp("d1005", {C1, C0, C0, C5}, {C1, C0, C0, C5});

        run_num("n50", 16'd50);
        check_disp("d50", {CB, CB, C5, C0}, {C0, C0, C5, C0});

        run_num("n9999", 16'd9999);
        check_disp("d9999", {C9, C9, C9, C9}, {C9, C9, C9, C9});

        strobe(16'hDEAD, 1'b1);
        chk("err_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("err_done", {31'd0, busy}, 32'd0);
        check_disp("derr", {CE, CR, CR, CB}, {CE, CR, CR, CB});

        strobe(16'd10000, 1'b0);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("ovf_done", {31'd0, busy}, 32'd0);
        check_disp("dovf", {CD, CD, CD, CD}, {CD, CD, CD, CD});

        strobe(16'd999, 1'b0);
        for (int i = 0; i < 17; i++) begin
            chk("n999_busy", {31'd0, busy}, 32'd1);
            result_valid = (i == 4);
            result       = (i == 4) ? 16'd42 : 16'd999;
            tick;
            result_valid = 1'b0;
        end
        chk("n999_done", {31'd0, busy}, 32'd0);
        check_disp("d999", {CB, C9, C9, C9}, {C0, C9, C9, C9});

        strobe(16'd0, 1'b1);
        result       = 16'd8;
        result_valid = 1'b1;
        tick;
        result_valid = 1'b0;
        chk("commit_drop", {31'd0, busy}, 32'd0);
        run_num("n3", 16'd3);
        check_disp("d3", {CB, CB, CB, C3}, {C0, C0, C0, C3});

        strobe(16'd1234, 1'b0);
        repeat (8) tick;
        reset = 1'b1;
        tick;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_anode", {28'd0, anode}, 32'b0111);
        chk("mid_cath", {24'd0, cathodes}, {24'd0, CB});
        reset = 1'b0;
        check_disp("dmid", {CB, CB, CB, C0}, {CB, CB, CB, C0});

        run_num("n5", 16'd5);
        check_disp("d5", {CB, CB, CB, C5}, {C0, C0, C0, C5});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
